eqn_code_lock: RTL and testbench
================================

Name: eqn_code_lock

Overview:
- Parametrised successor to the 4-bit two-button equality checker.
- Operator programs a multi-digit secret code with push1 and enters attempts with push2, one WIDTH-bit digit per press on `no`.
- Drives ledpin on a correct attempt.
- Adds input synchronisation, edge detection, digit sequencing, entry timeout and a failed-attempt lockout, none of which the single-compare block has.

Parameters:
- WIDTH, 4, bits per digit on `no`.
- DIGITS, 4, digits per code (>=1).
- MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCK_CYCLES, 1000, clk cycles spent in LOCKOUT.
- TIMEOUT, 5000, idle clk cycles allowed between digit events in PROG/ENTER.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- no  in  WIDTH  digit value, sampled on the clk edge that registers a push event.
- push1  in  1  program button, asynchronous level.
- push2  in  1  enter button, asynchronous level.
- ledpin  out  1  high while state is OPEN.
- err  out  1  one-cycle pulse on any rejected or failed operation.
- locked  out  1  high while state is LOCKOUT.
- code_valid  out  1  a complete code has been committed.
- digit_idx  out  $clog2(DIGITS+1)  digits accepted in the current PROG/ENTER sequence.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, state IDLE, fail count 0.
  - Stored code and shadow buffer cleared.
  - Synchroniser flops cleared.
- Inputs:
  - Each push passes through a 2-flop synchroniser, then rising-edge detection against a third flop.
  - An event is acted on at the 3rd rising clk edge at which the button is sampled high after being low.
  - Held buttons give exactly one event.
  - `no` is sampled raw on the acting edge; the operator must hold it stable.
- Both push1 and push2 events in the same cycle: both discarded, err pulse, state unchanged (no err in LOCKOUT).
- IDLE:
  - push1 event: shadow[0]<=no, digit_idx=1, go PROG.
  - push2 event with code_valid=1: compare no with code[0], set mismatch flag, digit_idx=1, go ENTER.
  - push2 event with code_valid=0: err pulse, stay IDLE.
  - DIGITS=1 completes on this first event (see PROG/ENTER completion).
- PROG:
  - push1 event: shadow[digit_idx]<=no, digit_idx++.
  - On the DIGITS-th digit: copy shadow to code, code_valid=1, digit_idx=0, go IDLE.
  - push2 event: err pulse, ignored.
- ENTER:
  - push2 event: mismatch |= (no != code[digit_idx]), digit_idx++.
  - push1 event: err pulse, ignored.
  - On the DIGITS-th digit with no mismatch: go OPEN, fail count=0.
  - On the DIGITS-th digit with a mismatch: err pulse, fail count++.
    - If fail count reaches MAX_TRIES: go LOCKOUT.
    - Otherwise go IDLE.
  - digit_idx returns to 0 in either case.
- Timeout (PROG/ENTER):
  - Counter resets on each accepted digit and counts clk cycles otherwise.
  - At TIMEOUT cycles: err pulse, digit_idx=0, go IDLE.
  - Abort from PROG leaves the previous code and code_valid untouched.
  - Abort from ENTER does not increment fail count.
- OPEN:
  - ledpin=1 from the edge following completion.
  - Any push event (consumed, no action) returns to IDLE and ledpin=0 on that edge.
  - No timeout in OPEN.
- LOCKOUT:
  - locked=1 for exactly LOCK_CYCLES cycles; all push events ignored silently.
  - At expiry: fail count=0, locked=0, go IDLE.
- Reset mid-sequence (any state) returns to IDLE with code_valid=0; the code is lost.
- Widths:
  - Fail counter $clog2(MAX_TRIES+1).
  - Timeout/lock counters sized for max(TIMEOUT, LOCK_CYCLES).
  - No wrap is permitted; counters saturate at their terminal value.

Test Plan:
(DIGITS=4, WIDTH=4, MAX_TRIES=3, LOCK_CYCLES=16, TIMEOUT=64; each digit is a push pulse of >=3 cycles.)
- Program with push1 digits 3,7,0,F → after 4th event code_valid=1, digit_idx=0, err never pulses. Then push2 digits 3,7,0,F → ledpin=1 within one edge of the 4th event. Then any push → ledpin=0.
- After programming 3,7,0,F, enter 3,7,1,F three times → err pulses once per attempt. Third failure raises locked for exactly 16 cycles. Pushes during lockout produce no err. Afterwards, correct entry opens.
- Reset with code_valid=0, push2 digit 5 → err one-cycle pulse, state IDLE, digit_idx=0.
- Program 3,7,0,F. Start reprogramming with 1,2, then wait 64 cycles → err pulse, digit_idx=0. Entering 3,7,0,F still opens, proving the old code was retained.
- Hold push2 high for 20 cycles → digit_idx increments by exactly 1. Raise push1 and push2 on the same cycle → err pulse, digit_idx unchanged.
- Assert rst_n=0 asynchronously mid-ENTER (between clk edges) → all outputs 0 immediately, code_valid=0 after release.

Source files
------------

// File: rtl/eqn_code_lock.sv
// Multi-digit programmable code lock: push1 programs a DIGITS-long code, push2 enters attempts,
// with synchronised button edges, idle-entry timeout and a lockout after repeated failures.
module eqn_code_lock #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             no,
  input  logic                         push1,
  input  logic                         push2,
  output logic                         ledpin,
  output logic                         err,
  output logic                         locked,
  output logic                         code_valid,
  output logic [$clog2(DIGITS+1)-1:0]  digit_idx
);

  localparam int unsigned IW   = $clog2(DIGITS + 1);
  localparam int unsigned AW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned CMAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_ENTER,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t                       state;
  logic [2:0]                   p1_sync;
  logic [2:0]                   p2_sync;
  logic [DIGITS-1:0][WIDTH-1:0] code;
  logic [DIGITS-1:0][WIDTH-1:0] shadow;
  logic                         mismatch;
  logic [FW-1:0]                fails;
  logic [CW-1:0]                cnt;

  logic          ev1, ev2, both, p1_only, p2_only;
  logic          prog_acc, enter_acc, last, mm_next, timeout_hit, lock_done;
  logic [AW-1:0] idx;

  // Rising edge seen at the second sync stage versus the third
  assign ev1     = p1_sync[1] & ~p1_sync[2];
  assign ev2     = p2_sync[1] & ~p2_sync[2];
  assign both    = ev1 & ev2;
  assign p1_only = ev1 & ~ev2;
  assign p2_only = ev2 & ~ev1;

  assign idx         = AW'(digit_idx);
  assign last        = (digit_idx == IW'(DIGITS - 1));
  assign prog_acc    = p1_only & ((state == S_IDLE) | (state == S_PROG));
  assign enter_acc   = p2_only & (((state == S_IDLE) & code_valid) | (state == S_ENTER));
  assign mm_next     = ((state == S_ENTER) & mismatch) | (no != code[idx]);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign lock_done   = (cnt == CW'(LOCK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_sync <= '0;
      p2_sync <= '0;
    end else begin
      p1_sync <= {p1_sync[1:0], push1};
      p2_sync <= {p2_sync[1:0], push2};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      code       <= '0;
      shadow     <= '0;
      mismatch   <= 1'b0;
      fails      <= '0;
      cnt        <= '0;
      ledpin     <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      code_valid <= 1'b0;
      digit_idx  <= '0;
    end else begin
      err <= 1'b0;
      if (prog_acc) begin
        cnt <= '0;
        if (last) begin
          code       <= shadow;
          code[idx]  <= no;
          code_valid <= 1'b1;
          digit_idx  <= '0;
          state      <= S_IDLE;
        end else begin
          shadow[idx] <= no;
          digit_idx   <= digit_idx + IW'(1);
          state       <= S_PROG;
        end
      end else if (enter_acc) begin
        cnt <= '0;
        if (last) begin
          digit_idx <= '0;
          mismatch  <= 1'b0;
          if (!mm_next) begin
            state  <= S_OPEN;
            ledpin <= 1'b1;
            fails  <= '0;
          end else begin
            err <= 1'b1;
            if (fails == FW'(MAX_TRIES - 1)) begin
              fails  <= FW'(MAX_TRIES);
              state  <= S_LOCKOUT;
              locked <= 1'b1;
            end else begin
              fails <= fails + FW'(1);
              state <= S_IDLE;
            end
          end
        end else begin
          mismatch  <= mm_next;
          digit_idx <= digit_idx + IW'(1);
          state     <= S_ENTER;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (both | p2_only) err <= 1'b1;
          end
          S_PROG, S_ENTER: begin
            if (both | ((state == S_PROG) & p2_only) | ((state == S_ENTER) & p1_only))
              err <= 1'b1;
            // Abort leaves code, code_valid and fail count untouched
            if (timeout_hit) begin
              err       <= 1'b1;
              digit_idx <= '0;
              mismatch  <= 1'b0;
              cnt       <= '0;
              state     <= S_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_OPEN: begin
            if (both) begin
              err <= 1'b1;
            end else if (ev1 | ev2) begin
              ledpin <= 1'b0;
              state  <= S_IDLE;
            end
          end
          S_LOCKOUT: begin
            if (lock_done) begin
              cnt    <= '0;
              fails  <= '0;
              locked <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eqn_code_lock.sv
// Directed self-checking bench for eqn_code_lock (DIGITS=4, WIDTH=4, MAX_TRIES=3, LOCK_CYCLES=16, TIMEOUT=64).
module tb_eqn_code_lock;

  logic       clk;
  logic       rst_n;
  logic [3:0] no;
  logic       push1;
  logic       push2;
  logic       ledpin;
  logic       err;
  logic       locked;
  logic       code_valid;
  logic [2:0] digit_idx;

  int checks = 0;
  int errors = 0;
  int err_hi = 0;
  int lock_hi = 0;

  eqn_code_lock #(
    .WIDTH(4), .DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .no(no), .push1(push1), .push2(push2),
    .ledpin(ledpin), .err(err), .locked(locked), .code_valid(code_valid),
    .digit_idx(digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles during which err / locked were high
  always @(posedge clk) begin
    if (err === 1'b1) err_hi = err_hi + 1;
    if (locked === 1'b1) lock_hi = lock_hi + 1;
  end

  task automatic press(input bit b, input logic [3:0] d);
    @(negedge clk);
    no = d;
    if (b) push2 = 1'b1; else push1 = 1'b1;
    repeat (4) @(negedge clk);
    push1 = 1'b0;
    push2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; push1 = 1'b0; push2 = 1'b0; no = 4'h0;
    repeat (3) @(negedge clk);
    if ({ledpin, err, locked, code_valid, digit_idx} !== 7'b0) begin
      $display("FAIL reset_outputs: got %b expected 0000000", {ledpin, err, locked, code_valid, digit_idx});
      errors++;
    end
    checks++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_code;
    int e0;
    e0 = err_hi;
    press(1'b1, 4'h5);
    if (err_hi - e0 !== 1) begin
      $display("FAIL nocode_err: got %0d err cycles expected 1", err_hi - e0); errors++;
    end
    checks++;
    if (digit_idx !== 3'd0) begin
      $display("FAIL nocode_idx: got %0d expected 0", digit_idx); errors++;
    end
    checks++;
  endtask

  task automatic test_program;
    logic [3:0] digs [4] = '{4'h3, 4'h7, 4'h0, 4'hF};
    int e0;
    e0 = err_hi;
    for (int i = 0; i < 4; i++) begin
      press(1'b0, digs[i]);
      if (i < 3 && digit_idx !== 3'(i + 1)) begin
        $display("FAIL prog_idx%0d: got %0d expected %0d", i, digit_idx, i + 1); errors++;
      end
      if (i < 3) checks++;
    end
    if (code_valid !== 1'b1 || digit_idx !== 3'd0) begin
      $display("FAIL prog_commit: got valid=%b idx=%0d expected valid=1 idx=0", code_valid, digit_idx); errors++;
    end
    checks++;
    if (err_hi != e0) begin
      $display("FAIL prog_noerr: got %0d err cycles expected 0", err_hi - e0); errors++;
    end
    checks++;
  endtask

  task automatic test_open;
    logic [3:0] digs [4] = '{4'h3, 4'h7, 4'h0, 4'hF};
    for (int i = 0; i < 4; i++) press(1'b1, digs[i]);
    if (ledpin !== 1'b1) begin
      $display("FAIL open_led: got %b expected 1", ledpin); errors++;
    end
    checks++;
    press(1'b0, 4'h9);
    if (ledpin !== 1'b0 || code_valid !== 1'b1) begin
      $display("FAIL open_close: got led=%b valid=%b expected led=0 valid=1", ledpin, code_valid); errors++;
    end
    checks++;
  endtask

  task automatic test_lockout;
    logic [3:0] bad [4] = '{4'h3, 4'h7, 4'h1, 4'hF};
    logic [3:0] good [4] = '{4'h3, 4'h7, 4'h0, 4'hF};
    int e0;
    int k;
    for (int a = 0; a < 3; a++) begin
      e0 = err_hi;
      if (a == 2) lock_hi = 0;
      for (int i = 0; i < 4; i++) press(1'b1, bad[i]);
      if (err_hi - e0 !== 1) begin
        $display("FAIL bad_err%0d: got %0d err cycles expected 1", a, err_hi - e0); errors++;
      end
      checks++;
      if (locked !== (a == 2)) begin
        $display("FAIL bad_locked%0d: got %b expected %b", a, locked, (a == 2)); errors++;
      end
      checks++;
    end
    e0 = err_hi;
    press(1'b1, 4'h3);
    if (err_hi != e0) begin
      $display("FAIL lock_silent: got %0d err cycles expected 0", err_hi - e0); errors++;
    end
    checks++;
    k = 0;
    while (locked === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (lock_hi !== 16) begin
      $display("FAIL lock_len: got %0d cycles expected 16", lock_hi); errors++;
    end
    checks++;
    for (int i = 0; i < 4; i++) press(1'b1, good[i]);
    if (ledpin !== 1'b1) begin
      $display("FAIL post_lock_open: got %b expected 1", ledpin); errors++;
    end
    checks++;
    press(1'b1, 4'h0);
  endtask

  task automatic test_timeout;
    logic [3:0] good [4] = '{4'h3, 4'h7, 4'h0, 4'hF};
    int k;
    bit seen;
    press(1'b0, 4'h1);
    press(1'b0, 4'h2);
    if (digit_idx !== 3'd2) begin
      $display("FAIL reprog_idx: got %0d expected 2", digit_idx); errors++;
    end
    checks++;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (err === 1'b1) seen = 1'b1;
    end
    if (!seen || k != 60) begin
      $display("FAIL timeout_at: got seen=%b after %0d cycles expected seen=1 after 60", seen, k); errors++;
    end
    checks++;
    if (digit_idx !== 3'd0 || code_valid !== 1'b1) begin
      $display("FAIL timeout_state: got idx=%0d valid=%b expected idx=0 valid=1", digit_idx, code_valid); errors++;
    end
    checks++;
    for (int i = 0; i < 4; i++) press(1'b1, good[i]);
    if (ledpin !== 1'b1) begin
      $display("FAIL old_code_open: got %b expected 1", ledpin); errors++;
    end
    checks++;
    press(1'b0, 4'h0);
  endtask

  task automatic test_hold_both;
    int e0;
    e0 = err_hi;
    @(negedge clk);
    no = 4'h3;
    push2 = 1'b1;
    repeat (20) @(negedge clk);
    push2 = 1'b0;
    repeat (3) @(negedge clk);
    if (digit_idx !== 3'd1 || err_hi != e0) begin
      $display("FAIL hold_once: got idx=%0d err cycles=%0d expected idx=1 err cycles=0", digit_idx, err_hi - e0); errors++;
    end
    checks++;
    e0 = err_hi;
    push1 = 1'b1;
    push2 = 1'b1;
    repeat (4) @(negedge clk);
    push1 = 1'b0;
    push2 = 1'b0;
    repeat (3) @(negedge clk);
    if (err_hi - e0 !== 1 || digit_idx !== 3'd1) begin
      $display("FAIL both_push: got err cycles=%0d idx=%0d expected 1 and 1", err_hi - e0, digit_idx); errors++;
    end
    checks++;
  endtask

  task automatic test_async_reset;
    int e0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    if ({ledpin, err, locked, code_valid, digit_idx} !== 7'b0) begin
      $display("FAIL async_reset: got %b expected 0000000", {ledpin, err, locked, code_valid, digit_idx}); errors++;
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    if (code_valid !== 1'b0) begin
      $display("FAIL reset_code_lost: got %b expected 0", code_valid); errors++;
    end
    checks++;
    e0 = err_hi;
    press(1'b1, 4'h3);
    if (err_hi - e0 !== 1 || ledpin !== 1'b0) begin
      $display("FAIL reset_enter_rejected: got err cycles=%0d led=%b expected 1 and 0", err_hi - e0, ledpin); errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_no_code();
    test_program();
    test_open();
    test_lockout();
    test_timeout();
    test_hold_both();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
